zbt_stream_writer: RTL and testbench



---
 rtl/zbt_pkg.sv | 19 +
 rtl/stream_hold_reg.sv | 46 ++++
 rtl/zbt_stream_writer.sv | 152 +++++++++++++++
 tb/tb_zbt_stream_writer.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zbt_pkg.sv
// Shared constants and FSM encoding for the ZBT stream writer.
// Word/byte address conversion, bus widths and the writer's state type.
package zbt_pkg;

    localparam int SRAM_AW    = 18;
    localparam int WB_AW      = 32;
    localparam int WB_DW      = 32;
    localparam int BYTE_SHIFT = 2;

    localparam logic [3:0] WB_SEL_ALL = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_WRITE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/stream_hold_reg.sv
// One-entry valid/ready holding register with a registered ready.
// ready is computed from next-cycle occupancy so it never needs a combinational path from valid.
module stream_hold_reg
    import zbt_pkg::*;
#(
    parameter int DW = WB_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] data,
    input  logic          valid,
    input  logic          allow,
    input  logic          drain,
    input  logic          flush,
    output logic          ready,
    output logic          full,
    output logic [DW-1:0] hold_data
);

    logic take;
    logic full_next;

    assign take = valid & ready;

    always_comb begin
        full_next = (full & ~drain) | take;
        if (flush) begin
            full_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full      <= 1'b0;
            ready     <= 1'b0;
            hold_data <= '0;
        end else begin
            full  <= full_next;
            ready <= allow & ~full_next;
            if (take) begin
                hold_data <= data;
            end
        end
    end

endmodule

// File: rtl/zbt_stream_writer.sv
// Wishbone master writing a valid/ready word stream to consecutive ZBT SRAM word addresses.
// state    | meaning
// ST_IDLE  | waiting for start_i
// ST_FILL  | busy, no beat on the bus, waiting for a held word
// ST_WRITE | cyc/stb high, beat in flight until wb_ack_i
// ST_DONE  | one-cycle done_o pulse, holding register flushed
module zbt_stream_writer
    import zbt_pkg::*;
#(
    parameter int AW    = SRAM_AW,
    parameter int LEN_W = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [AW-1:0]    base_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [LEN_W-1:0] count_o,
    input  logic [31:0]      data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [31:0]      wb_adr_o,
    output logic [31:0]      wb_dat_o,
    output logic [3:0]       wb_sel_o,
    output logic             wb_we_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    input  logic             wb_ack_i
);

    state_t            state, state_next;
    logic [LEN_W-1:0]  len_q, taken_q, count_q;
    logic [LEN_W-1:0]  len_next, taken_next;
    logic [AW-1:0]     adr_q;
    logic [WB_DW-1:0]  dat_q, hold_data;
    logic              abort_pend, abort_eff;
    logic              start_ok, beat_ack, last_beat;
    logic              hold_full, hold_take, launch, allow, flush;

    assign start_ok  = (state == ST_IDLE) & start_i;
    assign beat_ack  = (state == ST_WRITE) & wb_ack_i;
    assign last_beat = (count_q + LEN_W'(1)) == len_q;
    assign abort_eff = abort_pend | abort_i;
    assign hold_take = valid_i & ready_o;
    assign flush     = (state == ST_DONE);

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_next = (len_i == '0) ? ST_DONE : ST_FILL;
                end
            end
            ST_FILL: begin
                if (hold_full) begin
                    state_next = ST_WRITE;
                    launch     = 1'b1;
                end else if (abort_eff) begin
                    state_next = ST_DONE;
                end
            end
            ST_WRITE: begin
                // stb is never dropped before ack: the slave is already driving the SRAM write
                if (wb_ack_i) begin
                    if (last_beat || abort_eff) begin
                        state_next = ST_DONE;
                    end else if (hold_full) begin
                        launch = 1'b1;
                    end else begin
                        state_next = ST_FILL;
                    end
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        len_next   = start_ok ? len_i : len_q;
        taken_next = taken_q;
        if (start_ok) begin
            taken_next = '0;
        end else if (hold_take) begin
            taken_next = taken_q + LEN_W'(1);
        end
        allow = ((state_next == ST_FILL) || (state_next == ST_WRITE)) && (taken_next < len_next);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            len_q      <= '0;
            taken_q    <= '0;
            count_q    <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
            abort_pend <= 1'b0;
        end else begin
            state   <= state_next;
            len_q   <= len_next;
            taken_q <= taken_next;
            if (start_ok) begin
                count_q    <= '0;
                adr_q      <= base_i;
                abort_pend <= 1'b0;
            end else begin
                if (beat_ack) begin
                    count_q <= count_q + LEN_W'(1);
                    adr_q   <= adr_q + AW'(1);
                end
                if (state == ST_DONE) begin
                    abort_pend <= 1'b0;
                end else if (busy_o && abort_i) begin
                    abort_pend <= 1'b1;
                end
            end
            if (launch) begin
                dat_q <= hold_data;
            end
        end
    end

    stream_hold_reg #(.DW(WB_DW)) u_hold (
        .clk       (clk),
        .rst       (rst),
        .data      (data_i),
        .valid     (valid_i),
        .allow     (allow),
        .drain     (launch),
        .flush     (flush),
        .ready     (ready_o),
        .full      (hold_full),
        .hold_data (hold_data)
    );

    assign busy_o   = (state == ST_FILL) || (state == ST_WRITE);
    assign done_o   = (state == ST_DONE);
    assign count_o  = count_q;
    assign wb_cyc_o = (state == ST_WRITE);
    assign wb_stb_o = wb_cyc_o;
    assign wb_we_o  = wb_cyc_o;
    assign wb_sel_o = WB_SEL_ALL;
    assign wb_adr_o = {{(WB_AW-AW-BYTE_SHIFT){1'b0}}, adr_q, {BYTE_SHIFT{1'b0}}};
    assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_zbt_stream_writer.sv
// Bench for zbt_stream_writer: word-level reference model, Wishbone slave with delayed ack,
// randomized stream source, plus directed transfers with literal expectations.
module tb_zbt_stream_writer;

    localparam int AW    = 18;
    localparam int LEN_W = 18;

    logic             clk = 1'b0;
    logic             rst, start_i, abort_i, valid_i, wb_ack_i;
    logic [AW-1:0]    base_i;
    logic [LEN_W-1:0] len_i;
    logic [31:0]      data_i;
    logic             busy_o, done_o, ready_o, wb_we_o, wb_cyc_o, wb_stb_o;
    logic [LEN_W-1:0] count_o;
    logic [31:0]      wb_adr_o, wb_dat_o;
    logic [3:0]       wb_sel_o;

    always #5 clk = ~clk;

    zbt_stream_writer #(.AW(AW), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .base_i(base_i), .len_i(len_i),
        .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o), .count_o(count_o),
        .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Wishbone slave: ack once stb has been high for ack delay cycles of the current beat
    int   ack_min = 2, ack_max = 2, age = 0, cur_delay = 2;
    logic prev_stb = 1'b0, prev_ack = 1'b0;

    always @(posedge clk) begin
        #1;
        if (!wb_stb_o || !prev_stb || prev_ack) begin
            age       = 0;
            cur_delay = $urandom_range(ack_max, ack_min);
        end else begin
            age++;
        end
        wb_ack_i = wb_stb_o && (age >= cur_delay);
        prev_stb = wb_stb_o;
        prev_ack = wb_ack_i;
    end

    // Stream source
    logic [31:0] s_q[$];
    int   gap_min = 0, gap_max = 0, gap_left = 0;
    logic took = 1'b0;

    always @(posedge clk) begin
        #1;
        if (took) begin
            if (s_q.size() > 0) void'(s_q.pop_front());
            gap_left = $urandom_range(gap_max, gap_min);
        end
        if (gap_left > 0) begin
            valid_i = 1'b0;
            gap_left--;
        end else if (s_q.size() > 0) begin
            valid_i = 1'b1;
            data_i  = s_q[0];
        end else begin
            valid_i = 1'b0;
        end
    end

    // Reference model: word counts, in-flight flag and a queue of accepted words
    int          phase = 0;          // 0 idle, 1 busy, 2 done pulse
    logic [AW-1:0] base_m = '0;
    int          len_m = 0, taken_m = 0, acked_m = 0;
    bit          abort_m = 0, cyc_m = 0;
    logic [31:0] q_m[$];
    logic [31:0] log_adr[$], log_dat[$];
    int          done_pulses = 0, stb_falls = 0, cyc_cycles = 0;
    bit          chk_en = 0, prev_hold = 0, prev_stb_c = 0;
    logic [31:0] prev_adr = '0, prev_dat = '0;

    always @(negedge clk) begin : mdl
        int          hold_cnt, words;
        bit          take, ack, finish;
        logic [AW-1:0] wa;
        if (chk_en) begin
            hold_cnt = taken_m - acked_m - (cyc_m ? 1 : 0);
            check("busy", busy_o, phase == 1);
            check("done", done_o, phase == 2);
            check("cyc", wb_cyc_o, cyc_m);
            check("stb", wb_stb_o, cyc_m);
            check("we", wb_we_o, cyc_m);
            check("sel", wb_sel_o, 4'hF);
            check("count", count_o, acked_m);
            check("ready", ready_o, (phase == 1) && (hold_cnt == 0) && (taken_m < len_m));
            if (prev_hold && wb_stb_o) begin
                check("adr_stable", wb_adr_o, prev_adr);
                check("dat_stable", wb_dat_o, prev_dat);
            end
            take = valid_i && ready_o;
            ack  = wb_ack_i && wb_cyc_o;
            if (ack) begin
                wa = base_m + AW'(acked_m);
                check("beat_adr", wb_adr_o, {12'b0, wa, 2'b00});
                check("beat_dat", wb_dat_o, (q_m.size() > 0) ? q_m[0] : ~wb_dat_o);
                log_adr.push_back(wb_adr_o);
                log_dat.push_back(wb_dat_o);
            end
            if (done_o) done_pulses++;
            if (wb_cyc_o) cyc_cycles++;
            if (prev_stb_c && !wb_stb_o) stb_falls++;
            prev_stb_c = wb_stb_o;
            prev_hold  = wb_stb_o && !wb_ack_i;
            prev_adr   = wb_adr_o;
            prev_dat   = wb_dat_o;
            took       = take;
            if (rst) begin
                phase = 0; taken_m = 0; acked_m = 0; len_m = 0;
                abort_m = 0; cyc_m = 0; q_m.delete(); prev_hold = 0;
            end else begin
                case (phase)
                    0: if (start_i) begin
                        acked_m = 0;
                        if (len_i == 0) phase = 2;
                        else begin
                            phase = 1; base_m = base_i; len_m = len_i; taken_m = 0;
                            abort_m = 0; cyc_m = 0; q_m.delete();
                        end
                    end
                    2: phase = 0;
                    default: begin
                        finish = 0;
                        words  = taken_m - acked_m;
                        if (cyc_m) begin
                            if (ack) begin
                                acked_m++;
                                void'(q_m.pop_front());
                                if (acked_m == len_m || abort_m || abort_i) finish = 1;
                                else cyc_m = (words >= 2);
                            end
                        end else if (words >= 1) begin
                            cyc_m = 1;
                        end else if (abort_m || abort_i) begin
                            finish = 1;
                        end
                        if (take) begin
                            q_m.push_back(data_i);
                            taken_m++;
                        end
                        if (abort_i) abort_m = 1;
                        if (finish) begin
                            phase = 2; cyc_m = 0; q_m.delete();
                        end
                    end
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_xfer(input logic [AW-1:0] b, input logic [LEN_W-1:0] l);
        log_adr.delete();
        log_dat.delete();
        base_i  = b;
        len_i   = l;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, output int n);
        n = 0;
        while (done_pulses == d0 && n < budget) begin
            tick();
            n++;
        end
        if (done_pulses == d0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done_o within %0d cycles at %0t", budget, $time);
        end
    endtask

    initial begin
        int d0, n, f0, c0;
        rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; valid_i = 1'b0; wb_ack_i = 1'b0;
        base_i = '0; len_i = '0; data_i = '0;
        @(posedge clk);
        #2 chk_en = 1;
        tick(); tick();
        check("rst_busy", busy_o, 0);
        check("rst_cyc", wb_cyc_o, 0);
        check("rst_ready", ready_o, 0);
        check("rst_count", count_o, 0);
        check("rst_adr", wb_adr_o, 0);
        check("rst_dat", wb_dat_o, 0);
        rst = 1'b0;
        tick();

        // Back-to-back beats, ack two cycles after stb
        s_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        tick();
        d0 = done_pulses; f0 = stb_falls;
        start_xfer(18'h100, 4);
        wait_done(d0, 200, n);
        tick(); tick();
        check("t1_beats", log_adr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("t1_adr", log_adr[i], 32'h400 + 32'(4 * i));
            check("t1_dat", log_dat[i], 32'hA0 + 32'(i));
        end
        check("t1_count", count_o, 4);
        check("t1_done_once", done_pulses - d0, 1);
        check("t1_cycles", n, 15);
        check("t1_stb_continuous", stb_falls - f0, 1);

        // Zero length: done one cycle later, no bus activity
        d0 = done_pulses; c0 = cyc_cycles;
        start_xfer(18'h55, 0);
        wait_done(d0, 20, n);
        check("t2_latency", n, 1);
        check("t2_no_cyc", cyc_cycles - c0, 0);
        check("t2_count", count_o, 0);

        // Address wrap
        s_q = '{32'h1111_0000, 32'h2222_0000};
        tick();
        d0 = done_pulses;
        start_xfer(18'h3FFFF, 2);
        wait_done(d0, 200, n);
        tick();
        check("t3_adr0", log_adr[0], 32'hFFFFC);
        check("t3_adr1", log_adr[1], 32'h0);
        check("t3_dat1", log_dat[1], 32'h2222_0000);

        // Gaps of 5 cycles between stream words
        gap_min = 5; gap_max = 5;
        s_q = '{32'hC0, 32'hC1, 32'hC2};
        tick();
        d0 = done_pulses; f0 = stb_falls;
        start_xfer(18'h10, 3);
        wait_done(d0, 300, n);
        tick();
        check("t4_count", count_o, 3);
        check("t4_stb_drops", stb_falls - f0, 3);
        gap_min = 0; gap_max = 0;

        // Abort while stb high, ack delayed 4 cycles
        ack_min = 4; ack_max = 4;
        s_q = '{32'hD0, 32'hD1, 32'hD2, 32'hD3, 32'hD4, 32'hD5, 32'hD6, 32'hD7};
        tick();
        d0 = done_pulses; f0 = stb_falls;
        start_xfer(18'h20, 8);
        n = 0;
        while (!wb_stb_o && n < 50) begin tick(); n++; end
        check("t5_stb_seen", wb_stb_o, 1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        wait_done(d0, 200, n);
        tick(); tick();
        check("t5_beats", log_adr.size(), 1);
        check("t5_adr", log_adr[0], 32'h80);
        check("t5_dat", log_dat[0], 32'hD0);
        check("t5_count", count_o, 1);
        check("t5_stb_falls", stb_falls - f0, 1);
        s_q.delete();
        ack_min = 2; ack_max = 2;

        // start_i while busy is ignored
        gap_min = 2; gap_max = 2;
        s_q = '{32'hE0, 32'hE1, 32'hE2, 32'hE3, 32'hE4};
        tick();
        d0 = done_pulses;
        start_xfer(18'h200, 3);
        repeat (4) tick();
        base_i = 18'h300; len_i = 5; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_done(d0, 300, n);
        tick();
        check("t6_beats", log_adr.size(), 3);
        check("t6_adr2", log_adr[2], 32'h808);
        check("t6_count", count_o, 3);
        s_q.delete();
        gap_min = 0; gap_max = 0;

        // Reset mid-WRITE
        s_q = '{32'hF0, 32'hF1, 32'hF2, 32'hF3};
        tick();
        start_xfer(18'h40, 4);
        n = 0;
        while (!wb_stb_o && n < 50) begin tick(); n++; end
        check("t7_stb_seen", wb_stb_o, 1);
        rst = 1'b1;
        tick();
        check("t7_cyc", wb_cyc_o, 0);
        check("t7_stb", wb_stb_o, 0);
        check("t7_busy", busy_o, 0);
        check("t7_ready", ready_o, 0);
        rst = 1'b0;
        s_q.delete();
        tick(); tick();

        // Randomized transfers, lengths, delays, gaps and aborts
        for (int it = 0; it < 40; it++) begin
            int l;
            logic [AW-1:0] b;
            bit do_ab;
            l = $urandom_range(10, 1);
            b = (it % 4 == 0) ? AW'(18'h3FFFF - $urandom_range(4, 0)) : AW'($urandom);
            ack_min = 2; ack_max = $urandom_range(5, 2);
            gap_min = 0; gap_max = $urandom_range(3, 0);
            s_q.delete();
            for (int k = 0; k < l + 3; k++) s_q.push_back($urandom);
            do_ab = ($urandom_range(3, 0) == 0);
            tick();
            d0 = done_pulses;
            start_xfer(b, LEN_W'(l));
            if (do_ab) begin
                repeat ($urandom_range(15, 0)) tick();
                abort_i = 1'b1;
                tick();
                abort_i = 1'b0;
            end
            wait_done(d0, 400, n);
            tick();
            s_q.delete();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
